wishbone_master_bus_if: RTL and testbench
=========================================

Name: wishbone_master_bus_if

Overview:
- Upstream companion of the Wishbone-to-RAM sync bridge; one instance per CPU port (instruction fetch, data memory).
- Converts the pipeline's single-cycle memory request (ce/we/addr/data/sel) into a registered Wishbone classic master cycle.
- Holds the pipeline via stallreq_o until ack; buffers read data while the pipeline is stalled by other causes.
- Honours pipeline flush: aborts an outstanding cycle and drops its result.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SEL_WIDTH, 4, byte-select width
STALL_WIDTH, 6, width of pipeline stall vector
STALL_IDX, 1, stall_i bit that freezes the stage owning this port (1 = IF, 3 = MEM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
stall_i  in  STALL_WIDTH  pipeline stall vector from ctrl
flush_i  in  1  pipeline flush (exception)
cpu_ce_i  in  1  CPU request valid
cpu_we_i  in  1  1 = write
cpu_addr_i  in  ADDR_WIDTH  CPU address
cpu_data_i  in  DATA_WIDTH  CPU write data
cpu_sel_i  in  SEL_WIDTH  CPU byte selects
cpu_data_o  out  DATA_WIDTH  read data to CPU (combinational)
stallreq_o  out  1  stall request to ctrl (combinational)
wishbone_cyc_o  out  1  Wishbone cycle (registered)
wishbone_stb_o  out  1  Wishbone strobe (registered)
wishbone_we_o  out  1  Wishbone write enable (registered)
wishbone_addr_o  out  ADDR_WIDTH  Wishbone address (registered)
wishbone_data_o  out  DATA_WIDTH  Wishbone write data (registered)
wishbone_sel_o  out  SEL_WIDTH  Wishbone byte selects (registered)
wishbone_data_i  in  DATA_WIDTH  Wishbone read data
wishbone_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, rd_buf=0.
  - All wishbone_*_o = 0.
  - Reset mid-cycle drops cyc/stb immediately; no completion is reported.
- States: IDLE, BUSY, WAIT_FOR_STALL. Wishbone outputs change only on clk edges.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0:
    - Next edge: cyc=stb=1; latch we/addr/data/sel from CPU; go BUSY.
    - Same cycle: stallreq_o=1, cpu_data_o=0.
  - Otherwise: stallreq_o=0, cpu_data_o=0, outputs held 0.
  - wishbone_ack_i is ignored in IDLE.
- BUSY:
  - flush_i=1 has priority over ack:
    - Next edge: cyc=stb=we=0, addr/data/sel=0, rd_buf=0; go IDLE.
    - stallreq_o=0, cpu_data_o=0.
  - Else ack=1:
    - Next edge: clear all Wishbone outputs.
    - If the cycle is a read, rd_buf<=wishbone_data_i; a write leaves rd_buf unchanged.
    - Go WAIT_FOR_STALL if stall_i[STALL_IDX]=1, else IDLE.
    - Same cycle: stallreq_o=0; cpu_data_o=wishbone_data_i for a read, 0 for a write.
  - Else: stallreq_o=1, cpu_data_o=0; outputs held stable, including while stall_i changes.
- WAIT_FOR_STALL:
  - stallreq_o=0, cpu_data_o=rd_buf.
  - When stall_i[STALL_IDX]=0 or flush_i=1: next edge go IDLE; rd_buf cleared on flush.
  - No new Wishbone cycle starts in this state.
- Latency:
  - Request seen at edge N: stb high after edge N.
  - With the zero-latency bridge, ack arrives one cycle later, giving a 2-cycle pipeline stall per access.
  - After ack, stb drops on the next edge, so the slave sees exactly one strobed ack cycle.
- Back-to-back requests: a new cycle starts only from IDLE, so there is at least one idle bus cycle between accesses.
- Bus protocol:
  - cyc_o == stb_o at all times.
  - we/addr/data/sel remain constant while stb_o=1.

Test Plan:
- Single read: addr=0x0000_0010, slave returns 0xDEAD_BEEF with ack 1 cycle after stb -> stb high 2 cycles; stallreq_o high 2 cycles; cpu_data_o=0xDEAD_BEEF in the ack cycle; then IDLE with all outputs 0.
- Write, sel=4'b0011, data=0x1234_5678, addr=0x20 -> we_o=1, sel/data/addr stable until ack; cpu_data_o=0 in the ack cycle; rd_buf unchanged.
- Read ack while stall_i[STALL_IDX]=1, held 3 cycles -> FSM in WAIT_FOR_STALL; cpu_data_o holds the ack data for 3 cycles with stallreq_o=0; no stb; returns to IDLE when the stall drops.
- flush_i asserted in BUSY together with ack (data 0xAAAA_5555) -> cpu_data_o=0, stallreq_o=0, next state IDLE, rd_buf=0, stb dropped.
- Slave delays ack 5 cycles -> stallreq_o high 6 cycles; Wishbone outputs constant throughout.
- rst_n pulsed low while BUSY -> cyc/stb fall asynchronously; after release, FSM in IDLE; a fresh read completes normally.

Source files
------------

// File: rtl/wishbone_master_bus_if.sv
// Wishbone classic master for one CPU memory port: turns a single-cycle pipeline
// request into a registered bus cycle, stalls the pipeline until ack and honours flush.
module wishbone_master_bus_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int STALL_WIDTH = 6,
  parameter int STALL_IDX   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   flush_i,
  input  logic                   cpu_ce_i,
  input  logic                   cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]  cpu_data_i,
  input  logic [SEL_WIDTH-1:0]   cpu_sel_i,
  output logic [DATA_WIDTH-1:0]  cpu_data_o,
  output logic                   stallreq_o,
  output logic                   wishbone_cyc_o,
  output logic                   wishbone_stb_o,
  output logic                   wishbone_we_o,
  output logic [ADDR_WIDTH-1:0]  wishbone_addr_o,
  output logic [DATA_WIDTH-1:0]  wishbone_data_o,
  output logic [SEL_WIDTH-1:0]   wishbone_sel_o,
  input  logic [DATA_WIDTH-1:0]  wishbone_data_i,
  input  logic                   wishbone_ack_i
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  bus_active;
  logic                  start_cycle;
  logic                  end_cycle;

  assign start_cycle = (state == IDLE) && cpu_ce_i && !flush_i;
  assign end_cycle   = (state == BUSY) && (flush_i || wishbone_ack_i);

  // cyc and stb share one flop so they can never disagree
  assign wishbone_cyc_o = bus_active;
  assign wishbone_stb_o = bus_active;

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      IDLE: begin
        if (start_cycle) begin
          state_nxt  = BUSY;
          stallreq_o = 1'b1;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (wishbone_ack_i) begin
          state_nxt = stall_i[STALL_IDX] ? WAIT_FOR_STALL : IDLE;
          if (!wishbone_we_o) cpu_data_o = wishbone_data_i;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
        if (!stall_i[STALL_IDX] || flush_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_active      <= 1'b0;
      wishbone_we_o   <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_sel_o  <= '0;
      rd_buf          <= '0;
    end else if (start_cycle) begin
      bus_active      <= 1'b1;
      wishbone_we_o   <= cpu_we_i;
      wishbone_addr_o <= cpu_addr_i;
      wishbone_data_o <= cpu_data_i;
      wishbone_sel_o  <= cpu_sel_i;
    end else if (end_cycle) begin
      bus_active      <= 1'b0;
      wishbone_we_o   <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_sel_o  <= '0;
      if (flush_i)             rd_buf <= '0;
      else if (!wishbone_we_o) rd_buf <= wishbone_data_i;
    end else if ((state == WAIT_FOR_STALL) && flush_i) begin
      rd_buf <= '0;
    end
  end

endmodule

// File: tb/tb_wishbone_master_bus_if.sv
// Directed bench for wishbone_master_bus_if: stimulus pushes the expected per-cycle
// response into a queue, a monitor on the falling edge pops and compares.
module tb_wishbone_master_bus_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        wishbone_cyc_o;
  logic        wishbone_stb_o;
  logic        wishbone_we_o;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic [3:0]  wishbone_sel_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;

  wishbone_master_bus_if dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .wishbone_cyc_o(wishbone_cyc_o),
    .wishbone_stb_o(wishbone_stb_o), .wishbone_we_o(wishbone_we_o),
    .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
    .wishbone_sel_o(wishbone_sel_o), .wishbone_data_i(wishbone_data_i),
    .wishbone_ack_i(wishbone_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sr;
    logic [31:0] cd;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  sel;
  } exp_t;

  typedef struct {
    int   test;
    int   cyc;
    exp_t e;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    test_id = 0;
  int    cyc_no = 0;
  logic  rst_next = 1'b0;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] S1 = 6'b000010;
  localparam logic [5:0] S3 = 6'b001000;
  localparam logic [3:0] F  = 4'hF;

  task automatic step(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [5:0] st, input logic fl, input logic ak,
                      input logic [31:0] rd, input logic e_sr, input logic [31:0] e_cd,
                      input logic e_stb, input logic e_we, input logic [31:0] e_a,
                      input logic [31:0] e_d, input logic [3:0] e_s);
    item_t it;
    @(posedge clk);
    #1;
    rst_n           = rst_next;
    cpu_ce_i        = ce;
    cpu_we_i        = we;
    cpu_addr_i      = a;
    cpu_data_i      = d;
    cpu_sel_i       = s;
    stall_i         = st;
    flush_i         = fl;
    wishbone_ack_i  = ak;
    wishbone_data_i = rd;
    cyc_no++;
    it.test = test_id;
    it.cyc  = cyc_no;
    it.e    = '{sr: e_sr, cd: e_cd, stb: e_stb, we: e_we, addr: e_a, wd: e_d, sel: e_s};
    exp_q.push_back(it);
  endtask

  task automatic quiet(input logic [5:0] st);
    step(0, 0, 0, 0, 0, st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      exp_t  got;
      it  = exp_q.pop_front();
      got = '{sr: stallreq_o, cd: cpu_data_o, stb: wishbone_stb_o, we: wishbone_we_o,
              addr: wishbone_addr_o, wd: wishbone_data_o, sel: wishbone_sel_o};
      n_checks++;
      if (got !== it.e || wishbone_cyc_o !== it.e.stb) begin
        n_fail++;
        $display("FAIL t%0d_c%0d: got sr=%b cd=%h cyc=%b stb=%b we=%b a=%h d=%h s=%h, need sr=%b cd=%h cyc=stb=%b we=%b a=%h d=%h s=%h",
                 it.test, it.cyc, got.sr, got.cd, wishbone_cyc_o, got.stb, got.we, got.addr,
                 got.wd, got.sel, it.e.sr, it.e.cd, it.e.stb, it.e.we, it.e.addr, it.e.wd, it.e.sel);
      end
    end
  end

  initial begin
    // reset state
    test_id = 0;
    rst_next = 1'b0;
    quiet(S0);
    rst_next = 1'b1;
    quiet(S0);

    // single read, ack in the second strobed cycle
    test_id = 1;
    step(1, 0, 'h10, 0, F, S0, 0, 0, 0,           1, 0,           0, 0, 0,    0, 0);
    step(1, 0, 'h10, 0, F, S0, 0, 0, 0,           1, 0,           1, 0, 'h10, 0, F);
    step(1, 0, 'h10, 0, F, S0, 0, 1, 'hDEADBEEF,  0, 'hDEADBEEF,  1, 0, 'h10, 0, F);
    quiet(S0);

    // write, then ack under stall: WAIT shows the untouched read buffer
    test_id = 2;
    step(1, 1, 'h20, 'h12345678, 4'h3, S0, 0, 0, 0,          1, 0, 0, 0, 0,    0,           0);
    step(1, 1, 'h20, 'h12345678, 4'h3, S0, 0, 0, 0,          1, 0, 1, 1, 'h20, 'h12345678, 4'h3);
    step(1, 1, 'h20, 'h12345678, 4'h3, S1, 0, 1, 'hFFFFFFFF, 0, 0, 1, 1, 'h20, 'h12345678, 4'h3);
    step(1, 1, 'h20, 'h12345678, 4'h3, S1, 0, 0, 0,          0, 'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 1, 'h20, 'h12345678, 4'h3, S0, 0, 0, 0,          0, 'hDEADBEEF, 0, 0, 0, 0, 0);
    quiet(S0);

    // read ack with stall held; data held 3 cycles, ack in WAIT ignored
    test_id = 3;
    step(1, 0, 'h30, 0, F, S0, 0, 0, 0,          1, 0,           0, 0, 0,    0, 0);
    step(1, 0, 'h30, 0, F, S1, 0, 0, 0,          1, 0,           1, 0, 'h30, 0, F);
    step(1, 0, 'h30, 0, F, S1, 0, 1, 'hCAFEF00D, 0, 'hCAFEF00D,  1, 0, 'h30, 0, F);
    step(1, 0, 'h30, 0, F, S1, 0, 0, 0,          0, 'hCAFEF00D,  0, 0, 0,    0, 0);
    step(1, 0, 'h30, 0, F, S1, 0, 1, 'h11111111, 0, 'hCAFEF00D,  0, 0, 0,    0, 0);
    step(1, 0, 'h30, 0, F, S0, 0, 0, 0,          0, 'hCAFEF00D,  0, 0, 0,    0, 0);
    quiet(S0);

    // flush: blocks a start in IDLE, beats ack and stall in BUSY, clears rd_buf
    test_id = 4;
    step(1, 0, 'h40, 0, F, S0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet(S0);
    step(1, 0, 'h40, 0, F, S0, 0, 0, 0,          1, 0, 0, 0, 0,    0, 0);
    step(1, 0, 'h40, 0, F, S0, 0, 0, 0,          1, 0, 1, 0, 'h40, 0, F);
    step(1, 0, 'h40, 0, F, S1, 1, 1, 'hAAAA5555, 0, 0, 1, 0, 'h40, 0, F);
    quiet(S1);
    step(1, 1, 'h50, 1, F, S0, 0, 0, 0,          1, 0, 0, 0, 0,    0, 0);
    step(1, 1, 'h50, 1, F, S0, 0, 0, 0,          1, 0, 1, 1, 'h50, 1, F);
    step(1, 1, 'h50, 1, F, S1, 0, 1, 'h77777777, 0, 0, 1, 1, 'h50, 1, F);
    quiet(S0);
    quiet(S0);

    // slave delays ack 5 cycles; CPU inputs and stall wander, bus must not
    test_id = 5;
    step(1, 0, 'h60, 0, F, S0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 32'h99 + i, i, 4'(i), (i % 2 == 0) ? S1 : S3, 0, 0, 32'h5A5A0000 + i,
           1, 0, 1, 0, 'h60, 0, F);
    step(1, 0, 'h60, 0, F, S0, 0, 1, 'h0BADF00D, 0, 'h0BADF00D, 1, 0, 'h60, 0, F);
    quiet(S0);

    // async reset while BUSY, then a fresh read
    test_id = 6;
    step(1, 0, 'h70, 0, F, S0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0);
    step(1, 0, 'h70, 0, F, S0, 0, 0, 0, 1, 0, 1, 0, 'h70, 0, F);
    rst_next = 1'b0;
    step(0, 0, 0, 0, 0, S0, 0, 1, 'h12121212, 0, 0, 0, 0, 0, 0, 0);
    rst_next = 1'b1;
    quiet(S0);
    step(1, 0, 'h80, 0, 4'h5, S0, 0, 0, 0,          1, 0,          0, 0, 0,    0, 0);
    step(1, 0, 'h80, 0, 4'h5, S0, 0, 0, 0,          1, 0,          1, 0, 'h80, 0, 4'h5);
    step(1, 0, 'h80, 0, 4'h5, S0, 0, 1, 'h13579BDF, 0, 'h13579BDF, 1, 0, 'h80, 0, 4'h5);
    quiet(S0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
